// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM state, PC-select codes and the stall/flush bundle.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TRAP     = 2'd2
   } type_hz_state_e;

   localparam logic [1:0] PC_SEL_PC4  = 2'd0;
   localparam logic [1:0] PC_SEL_BR   = 2'd1;
   localparam logic [1:0] PC_SEL_TRAP = 2'd2;
   localparam logic [1:0] PC_SEL_EPC  = 2'd3;

   // Pipeline-register control bundle driven toward the F and DE stages.
   typedef struct packed {
      logic       stall_f;
      logic       stall_de;
      logic       stall_mw;
      logic       flush_de;
      logic       flush_mw;
      logic [1:0] pc_sel;
   } type_hz_ctr_s;

   // x0 is hard-wired zero, so a write to it must never be forwarded.
   function automatic logic fwd_hit(input logic [4:0] rd, input logic reg_wr,
                                    input logic [4:0] rs, input logic rs_used);
      return reg_wr && (rd != 5'd0) && (rd == rs) && rs_used;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// MW->DE operand forwarding compares for both source operands.
// Latency: purely combinational, zero cycles.
// Backpressure: none; selects follow the DE/MW register contents.
// Ports: de_rs1/de_rs2 + *_used from DE, mw_rd/mw_reg_wr from MW; fwd_a/fwd_b selects.
module hz_fwd_unit
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [4:0] de_rs1,
   input  logic [4:0] de_rs2,
   input  logic       de_rs1_used,
   input  logic       de_rs2_used,
   input  logic [4:0] mw_rd,
   input  logic       mw_reg_wr,
   output logic       fwd_a,
   output logic       fwd_b
);

   assign fwd_a = fwd_hit(mw_rd, mw_reg_wr, de_rs1, de_rs1_used);
   assign fwd_b = fwd_hit(mw_rd, mw_reg_wr, de_rs2, de_rs2_used);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/PC-select sequencer for the F / DE / MW pipeline, with mem timeout and precise traps.
// Latency: all controls are combinational in the cycle they apply; trap entry adds a one-cycle redirect slot.
// Backpressure: mem_ready low stalls F, DE and MW until completion or MEM_TIMEOUT low cycles (then bus_err).
// Ports: DE/MW hazard info and mem/irq status in; mem_req, stall_*/flush_*, fwd_a/b, pc_sel,
//        trap_take, bus_err pulses and a saturating stall_cnt out. rst is async active-low.
// MEM_TIMEOUT must be at least 2 (the first low cycle is spent entering MEM_WAIT).
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4:0]             de_rs1,
   input  logic [4:0]             de_rs2,
   input  logic                   de_rs1_used,
   input  logic                   de_rs2_used,
   input  logic                   de_mret,
   input  logic                   br_taken,
   input  logic [4:0]             mw_rd,
   input  logic                   mw_reg_wr,
   input  logic                   mw_mem_op,
   input  logic                   mem_ready,
   input  logic                   irq_pending,
   input  logic                   irq_en,
   output logic                   mem_req,
   output logic                   stall_f,
   output logic                   stall_de,
   output logic                   stall_mw,
   output logic                   flush_de,
   output logic                   flush_mw,
   output logic                   fwd_a,
   output logic                   fwd_b,
   output logic [1:0]             pc_sel,
   output logic                   trap_take,
   output logic                   bus_err,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   type_hz_state_e   state_q, state_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   type_hz_ctr_s ctr;
   logic         mem_req_c;
   logic         trap_take_c;
   logic         bus_err_c;
   logic         redirect_ok;
   logic         fwd_a_c;
   logic         fwd_b_c;

   hz_fwd_unit u_fwd (
      .de_rs1      (de_rs1),
      .de_rs2      (de_rs2),
      .de_rs1_used (de_rs1_used),
      .de_rs2_used (de_rs2_used),
      .mw_rd       (mw_rd),
      .mw_reg_wr   (mw_reg_wr),
      .fwd_a       (fwd_a_c),
      .fwd_b       (fwd_b_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      ctr         = '0;
      ctr.pc_sel  = PC_SEL_PC4;
      mem_req_c   = 1'b0;
      trap_take_c = 1'b0;
      bus_err_c   = 1'b0;
      redirect_ok = 1'b0;

      case (state_q)
         RUN: begin
            mem_req_c = mw_mem_op;
            if (mw_mem_op && !mem_ready) begin
               // Stall in the very cycle the access misses; the counter
               // already accounts for this first low cycle.
               ctr.stall_f  = 1'b1;
               ctr.stall_de = 1'b1;
               ctr.stall_mw = 1'b1;
               wait_cnt_d   = WC_W'(1);
               state_d      = MEM_WAIT;
            end else begin
               redirect_ok = 1'b1;
            end
         end
         MEM_WAIT: begin
            mem_req_c = mw_mem_op;
            if (mem_ready) begin
               // Pipeline advances this cycle, so a branch/mret/irq seen now
               // must be honoured or it would be lost.
               wait_cnt_d  = '0;
               state_d     = RUN;
               redirect_ok = 1'b1;
            end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
               // This is low cycle number MEM_TIMEOUT: abandon the access,
               // kill the younger DE instruction and vector to the handler.
               bus_err_c    = 1'b1;
               ctr.flush_mw = 1'b1;
               ctr.pc_sel   = PC_SEL_TRAP;
               wait_cnt_d   = '0;
               state_d      = TRAP;
            end else begin
               ctr.stall_f  = 1'b1;
               ctr.stall_de = 1'b1;
               ctr.stall_mw = 1'b1;
               wait_cnt_d   = wait_cnt_q + WC_W'(1);
            end
         end
         TRAP: begin
            // Discard whatever was fetched while the PC was being redirected.
            ctr.flush_de = 1'b1;
            state_d      = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (redirect_ok) begin
         if (irq_pending && irq_en) begin
            trap_take_c  = 1'b1;
            ctr.pc_sel   = PC_SEL_TRAP;
            ctr.flush_de = 1'b1;
            state_d      = TRAP;
         end else if (de_mret) begin
            ctr.pc_sel   = PC_SEL_EPC;
            ctr.flush_de = 1'b1;
         end else if (br_taken) begin
            ctr.pc_sel   = PC_SEL_BR;
            ctr.flush_de = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if (ctr.stall_f && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   // Every output is held at zero while reset is asserted, independent of
   // the data-path inputs, so downstream sees a quiet pipeline immediately.
   assign mem_req   = rst & mem_req_c;
   assign stall_f   = rst & ctr.stall_f;
   assign stall_de  = rst & ctr.stall_de;
   assign stall_mw  = rst & ctr.stall_mw;
   assign flush_de  = rst & ctr.flush_de;
   assign flush_mw  = rst & ctr.flush_mw;
   assign fwd_a     = rst & fwd_a_c;
   assign fwd_b     = rst & fwd_b_c;
   assign pc_sel    = rst ? ctr.pc_sel : PC_SEL_PC4;
   assign trap_take = rst & trap_take_c;
   assign bus_err   = rst & bus_err_c;
   assign stall_cnt = stall_cnt_q;

endmodule
